// File: rtl/counter_pkg.sv
// Shared constants and next-count arithmetic for the modulus counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the shared step function handles; callers zero-extend.
    localparam int unsigned CNT_MAX_W = 64;

    typedef struct packed {
        logic                 boundary;
        logic [CNT_MAX_W-1:0] next;
    } cnt_step_t;

    // Clamp against limit before any +/-1 so limit+1 is never produced.
    function automatic cnt_step_t cnt_next(
        input logic [CNT_MAX_W-1:0] cur,
        input logic [CNT_MAX_W-1:0] lim,
        input logic                 dir,
        input logic                 mode
    );
        cnt_step_t res;
        res.boundary = 1'b0;
        res.next     = cur;
        if (dir == DIR_UP) begin
            if (cur >= lim) begin
                res.boundary = 1'b1;
                res.next     = (mode == MODE_SAT) ? lim : '0;
            end else begin
                res.next = cur + CNT_MAX_W'(1);
            end
        end else begin
            if (cur == '0) begin
                res.boundary = 1'b1;
                res.next     = (mode == MODE_SAT) ? '0 : lim;
            end else begin
                res.next = cur - CNT_MAX_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE, emitting a step strobe on the terminal cycle.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic step_c_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q;
    logic [PW-1:0] ps_d;
    logic          last_c;

    assign last_c   = (ps_q == PS_LAST);
    assign step_c_o = enable_i & last_c;

    always_comb begin
        ps_d = ps_q;
        if (clear_i) begin
            ps_d = '0;
        end else if (enable_i) begin
            ps_d = last_c ? '0 : ps_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/counter_mod_nb.sv
// Up/down modulus counter with wrap/saturate, terminal-count pulse and sticky flag.
// Optional enabled-cycle prescaler when COUNTER_MOD_PRESCALER_EN is defined.
module counter_mod_nb
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             clear_flag,
    input  logic [WIDTH-1:0] value_load,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             bound_flag
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_W || PRESCALE < 1) begin : g_bad_param
        $error("counter_mod_nb: unsupported WIDTH or PRESCALE");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             flag_q, flag_d;
    logic             step_c;
    cnt_step_t        res_c;

`ifdef COUNTER_MOD_PRESCALER_EN
    logic ps_step_c;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (load),
        .enable_i (enable),
        .step_c_o (ps_step_c)
    );

    assign step_c = enable & ~load & ps_step_c;
`else
    assign step_c = enable & ~load;
`endif

    assign res_c = cnt_next(CNT_MAX_W'(out_q), CNT_MAX_W'(limit), up_down, sat_mode);

    // Load beats step; a boundary on the same edge beats clear_flag.
    always_comb begin
        out_d  = out_q;
        tc_d   = 1'b0;
        flag_d = flag_q;
        if (clear_flag) begin
            flag_d = 1'b0;
        end
        if (load) begin
            out_d = value_load;
        end else if (step_c) begin
            out_d = WIDTH'(res_c.next);
            tc_d  = res_c.boundary;
            if (res_c.boundary) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= WIDTH'(RESET_VAL);
            tc_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            tc_q   <= tc_d;
            flag_q <= flag_d;
        end
    end

    assign out        = out_q;
    assign tc         = tc_q;
    assign bound_flag = flag_q;

endmodule
